capture_sequencer_virtex6: RTL and testbench

Synchronous controller that shares the single configuration-readback capture input (CAP of the capture primitive) among up to NUM_REQ requesters. Performs round-robin arbitration, drives a clean CAP pulse of programmable width, enforces a guard interval between captures, and implements one-shot lockout with software re-arm. Sits in fabric directly in front of the capture primitive, on the same CLK.

---
 rtl/capture_seq_pkg.sv | 14 +
 rtl/capture_rr_arbiter.sv | 36 +++
 rtl/capture_sequencer_virtex6.sv | 146 ++++++++++++++
 tb/tb_capture_sequencer_virtex6.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/capture_seq_pkg.sv
// Shared types and widths for the capture sequencer.
package capture_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_GUARD,
    ST_LOCK
  } cap_state_e;

  localparam int CNT_W       = 4;
  localparam int CAP_COUNT_W = 16;

endpackage

// File: rtl/capture_rr_arbiter.sv
// Combinational round-robin select: priority starts at ptr and wraps upward.
module capture_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_req
);

  logic [NUM_REQ-1:0] rot_req;
  logic [NUM_REQ-1:0] rot_first;
  logic [NUM_REQ:0]   seen;
  logic [IDX_W-1:0]   idx_acc [0:NUM_REQ];

  // Rotate so the pointer position sits at bit 0, pick the lowest set bit, rotate back.
  assign rot_req = NUM_REQ'({req, req} >> ptr);
  assign seen[0] = 1'b0;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_first
    assign rot_first[gi] = rot_req[gi] & ~seen[gi];
    assign seen[gi+1]    = seen[gi] | rot_req[gi];
  end

  assign win_onehot = NUM_REQ'(({rot_first, rot_first} << ptr) >> NUM_REQ);
  assign any_req    = seen[NUM_REQ];

  assign idx_acc[0] = '0;
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_enc
    assign idx_acc[gi+1] = idx_acc[gi] | (win_onehot[gi] ? IDX_W'(gi) : '0);
  end
  assign win_idx = idx_acc[NUM_REQ];

endmodule

// File: rtl/capture_sequencer_virtex6.sv
// Shares the configuration-readback CAP input among NUM_REQ requesters:
// round-robin grant, fixed-width CAP pulse, guard gap and optional one-shot lock.
module capture_sequencer_virtex6
  import capture_seq_pkg::*;
#(
  parameter int    NUM_REQ      = 4,
  parameter int    CAP_WIDTH    = 2,
  parameter int    GUARD_CYCLES = 3,
  parameter string ONESHOT      = "TRUE"
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NUM_REQ-1:0]     REQ,
  input  logic                   REARM,
  output logic                   CAP,
  output logic [NUM_REQ-1:0]     GNT,
  output logic [NUM_REQ-1:0]     ACK,
  output logic                   BUSY,
  output logic                   LOCKED,
  output logic [CAP_COUNT_W-1:0] CAP_COUNT
);

  localparam int IDX_W      = $clog2(NUM_REQ);
  localparam bit ONESHOT_EN = (ONESHOT == "TRUE");

  if (NUM_REQ < 2 || NUM_REQ > 8 || CAP_WIDTH < 1 || CAP_WIDTH > 15 ||
      GUARD_CYCLES < 0 || GUARD_CYCLES > 15) begin : g_bad_range
    $fatal(1, "capture_sequencer_virtex6: parameter out of range");
  end
  if (ONESHOT != "TRUE" && ONESHOT != "FALSE") begin : g_bad_oneshot
    $fatal(1, "capture_sequencer_virtex6: ONESHOT must be TRUE or FALSE");
  end

  cap_state_e               state_reg, state_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic [IDX_W-1:0]         ptr_reg, ptr_next;
  logic [NUM_REQ-1:0]       gnt_reg, gnt_next;
  logic [NUM_REQ-1:0]       ack_reg, ack_next;
  logic                     cap_reg, busy_reg, locked_reg;
  logic                     cnt_inc;
  logic [CAP_COUNT_W-1:0]   cap_count_reg;

  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               any_req;

  capture_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req        (REQ),
    .ptr        (ptr_reg),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .any_req    (any_req)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    gnt_next   = gnt_reg;
    ack_next   = '0;
    cnt_inc    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          state_next = ST_ASSERT;
          cnt_next   = CNT_W'(CAP_WIDTH - 1);
          gnt_next   = win_onehot;
          ptr_next   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      ST_ASSERT: begin
        // The shared counter is reused for the guard interval on exit.
        if (cnt_reg == '0) begin
          ack_next = gnt_reg;
          gnt_next = '0;
          cnt_inc  = 1'b1;
          if (GUARD_CYCLES > 0) begin
            state_next = ST_GUARD;
            cnt_next   = CNT_W'(GUARD_CYCLES - 1);
          end else if (ONESHOT_EN) begin
            state_next = ST_LOCK;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_GUARD: begin
        if (cnt_reg == '0) begin
          state_next = ONESHOT_EN ? ST_LOCK : ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_LOCK: begin
        if (REARM) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      ptr_reg    <= '0;
      gnt_reg    <= '0;
      ack_reg    <= '0;
      cap_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      locked_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      ptr_reg    <= ptr_next;
      gnt_reg    <= gnt_next;
      ack_reg    <= ack_next;
      cap_reg    <= (state_next == ST_ASSERT);
      busy_reg   <= (state_next == ST_ASSERT) || (state_next == ST_GUARD);
      locked_reg <= (state_next == ST_LOCK);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cap_count_reg <= '0;
    end else if (cnt_inc && (cap_count_reg != '1)) begin
      cap_count_reg <= cap_count_reg + 1'b1;
    end
  end

  assign CAP       = cap_reg;
  assign GNT       = gnt_reg;
  assign ACK       = ack_reg;
  assign BUSY      = busy_reg;
  assign LOCKED    = locked_reg;
  assign CAP_COUNT = cap_count_reg;

endmodule

// File: tb/tb_capture_sequencer_virtex6.sv
// Randomized scoreboard bench: three configurations run side by side, each against a timing-level model.
module tb_capture_sequencer_virtex6;

  localparam int NR = 4;
  localparam int W_T [3] = '{2, 4, 1};
  localparam int G_T [3] = '{3, 2, 0};

  typedef struct {
    int          win;
    int          gedge;
    logic [15:0] cnt;
  } cap_t;

  logic clk = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  function automatic void check(input string name, input int cfg, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL cfg%0d %s: got %0d, expected %0d", cfg, name, act, exp);
    end
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int    W    = W_T[gi];
    localparam int    G    = G_T[gi];
    localparam bit    OS   = (gi == 1);
    localparam string OS_S = (gi == 1) ? "TRUE" : "FALSE";

    logic          rst_n, rearm, cap, busy, locked;
    logic [NR-1:0] req, gnt, ack;
    logic [15:0]   cap_count;

    capture_sequencer_virtex6 #(
      .NUM_REQ      (NR),
      .CAP_WIDTH    (W),
      .GUARD_CYCLES (G),
      .ONESHOT      (OS_S)
    ) u_dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .REQ       (req),
      .REARM     (rearm),
      .CAP       (cap),
      .GNT       (gnt),
      .ACK       (ack),
      .BUSY      (busy),
      .LOCKED    (locked),
      .CAP_COUNT (cap_count)
    );

    // Reference model: decides at each edge from the grant timing rules alone.
    cap_t        q[$];
    int          n = 0;
    int          free_at = 0;
    int          lock_from = 0;
    int          last_g = -100;
    bit          lock_active = 1'b0;
    bit          m_rst = 1'b1;
    bit          exp_busy = 1'b0;
    bit          exp_locked = 1'b0;
    logic [1:0]  ptr = 2'd0;
    logic [15:0] m_cnt = 16'd0;

    always @(posedge clk) begin
      logic [1:0] w;
      n++;
      if (!rst_n) begin
        m_rst = 1'b1; free_at = n + 1; lock_active = 1'b0; ptr = 2'd0;
        m_cnt = 16'd0; last_g = -100; q.delete();
      end else begin
        m_rst = 1'b0;
        if (lock_active && n > lock_from && rearm) begin
          lock_active = 1'b0;
          free_at = n + 1;
        end else if (n >= free_at && req != '0) begin
          w = ptr;
          while (!req[w]) w = w + 2'd1;
          ptr = w + 2'd1;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          q.push_back('{int'(w), n, m_cnt});
          last_g = n;
          if (OS) begin
            lock_active = 1'b1;
            lock_from = n + W + G;
            free_at = 32'h7fff_ffff;
          end else begin
            free_at = n + W + G + 1;
          end
        end
      end
      exp_busy   = !m_rst && n >= last_g && n <= last_g + W + G - 1;
      exp_locked = lock_active && n >= lock_from;
    end

    // Monitor: pops an expected capture on each CAP rising edge.
    cap_t cur;
    bit   prev_cap = 1'b0;
    bit   have_last = 1'b0;
    int   run = 0;
    int   last_fall = 0;

    always @(negedge clk) begin
      if (n >= 1) begin
        if (m_rst) begin
          check("reset_outputs", gi, {cap, gnt, ack, busy, locked, cap_count}, 0);
          prev_cap = 1'b0; run = 0; have_last = 1'b0;
        end else begin
          if (cap && !prev_cap) begin
            check("capture_expected", gi, q.size() > 0, 1);
            if (q.size() > 0) begin
              cur = q.pop_front();
              check("grant_onehot", gi, gnt, longint'(1) << cur.win);
              check("grant_edge", gi, n, cur.gedge);
              if (have_last) check("low_gap_min", gi, (n - last_fall) >= G + 1, 1);
            end
            run = 1;
          end else if (cap) begin
            run++;
            check("grant_hold", gi, gnt, longint'(1) << cur.win);
          end else if (prev_cap) begin
            check("cap_width", gi, run, W);
            check("ack_owner", gi, ack, longint'(1) << cur.win);
            check("gnt_clear", gi, gnt, 0);
            check("cap_count", gi, cap_count, cur.cnt);
            last_fall = n; have_last = 1'b1;
            $display("[TB] cfg%0d capture req%0d granted at edge %0d, CAP_COUNT=%h",
                     gi, cur.win, cur.gedge, cap_count);
          end else begin
            check("ack_quiet", gi, ack, 0);
          end
          check("busy", gi, busy, exp_busy);
          check("locked", gi, locked, exp_locked);
          prev_cap = cap;
        end
      end
    end

    // Stimulus: requesters hold REQ until ACK, except for random early drops once granted.
    initial begin
      bit did_rst;
      did_rst = 1'b0;
      rst_n = 1'b0; req = '1; rearm = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1; req = '0;
      @(negedge clk);
      force u_dut.cap_count_reg = 16'hFFFE;
      m_cnt = 16'hFFFE;
      @(negedge clk);
      release u_dut.cap_count_reg;
      for (int k = 0; k < 700; k++) begin
        @(negedge clk);
        rst_n = 1'b1;
        if (k >= 350 && !did_rst && cap) begin
          rst_n = 1'b0;
          did_rst = 1'b1;
        end
        for (int i = 0; i < NR; i++) begin
          if (!req[2'(i)]) req[2'(i)] = ($urandom_range(0, 3) == 0);
          else if (ack[2'(i)]) req[2'(i)] = ($urandom_range(0, 2) == 0);
          else if (gnt[2'(i)] && $urandom_range(0, 5) == 0) req[2'(i)] = 1'b0;
        end
        rearm = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      rst_n = 1'b1; req = '0; rearm = 1'b0;
      repeat (W + G + 4) @(negedge clk);
      check("drained", gi, q.size(), 0);
      check("cap_idle", gi, cap, 0);
      done_cnt++;
    end
  end

  initial begin
    wait (done_cnt == 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, done_cnt=%0d expected 3", done_cnt);
    $fatal(1, "timeout");
  end

endmodule
